// File: rtl/serial_shift_out_pkg.sv
// Shared definitions for the serial shift-out driver: FSM state encoding
// and a constant-function clog2 used to size counters.
package serial_shift_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Smallest r with 2**r >= value; loop is bounded so it elaborates statically.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_shift_out_clk_phase_div.sv
// Phase counter for one serial bit: 2*DIV clk cycles per bit, sclk low for the
// first half and high for the second, with a strobe on the last phase.
module clk_phase_div #(
  parameter int DIV   = 4,
  parameter int CNT_W = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic sclk_lvl_o,
  output logic bit_end_o
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * DIV - 1);

  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] phase_d;

  // Next phase: wraps at the end of a bit, held at zero while disabled.
  always_comb begin
    phase_d = phase_q;
    if (clr_i || !en_i) begin
      phase_d = '0;
    end else if (phase_q == LAST) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + CNT_W'(1);
    end
  end

  // Phase register.
  always_ff @(posedge clk_i) begin
    if (rst_i) phase_q <= '0;
    else       phase_q <= phase_d;
  end

  assign sclk_lvl_o = en_i && (phase_q >= HALF);
  assign bit_end_o  = en_i && (phase_q == LAST);

endmodule

// File: rtl/serial_shift_out.sv
// Serialises one DATA_WIDTH-bit word onto a shift-register chain (sclk/sdo),
// then pulses latch and reports completion with a one-cycle done.
// Handshake: a word is accepted on a rising clk edge where start && ready;
// data is sampled on that edge only; start at any other time is dropped.
module serial_shift_out
  import serial_shift_out_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int DIV          = 4,
  parameter int MSB_FIRST    = 1,
  parameter int LATCH_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  sdo,
  output logic                  latch
);

  localparam int LAT_L   = (LATCH_CYCLES == 0) ? 2 * DIV : LATCH_CYCLES;
  localparam int CNT_MAX = (2 * DIV > LAT_L) ? 2 * DIV : LAT_L;
  localparam int CNT_W   = clog2(CNT_MAX + 1);
  localparam int BIT_W   = clog2(DATA_WIDTH + 1);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_LAT = CNT_W'(LAT_L - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic                  accept;
  logic                  sclk_lvl;
  logic                  bit_end;

  assign accept = (state_q == ST_IDLE) && start;

  clk_phase_div #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_phase (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (accept),
    .en_i       (state_q == ST_SHIFT),
    .sclk_lvl_o (sclk_lvl),
    .bit_end_o  (bit_end)
  );

  // FSM next state, shift register and counters; outputs decode the state.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    lat_cnt_d = lat_cnt_q;
    ready     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    sclk      = 1'b0;
    sdo       = 1'b0;
    latch     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start) begin
          sr_d      = data;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sclk = sclk_lvl;
        sdo  = (MSB_FIRST != 0) ? sr_q[DATA_WIDTH-1] : sr_q[0];
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            lat_cnt_d = '0;
            state_d   = ST_LATCH;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            sr_d      = (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);
          end
        end
      end
      ST_LATCH: begin
        latch     = 1'b1;
        lat_cnt_d = lat_cnt_q + CNT_W'(1);
        if (lat_cnt_q == LAST_LAT) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

endmodule
